// File: rtl/ip_fetch_unit.sv
// Instruction-pointer / fetch stage feeding the decoder: owns IP, operand latch and IR.
// Optional retired-instruction counter on o_retired is built when IP_TRACE_EN is defined.
module ip_fetch_unit #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_IP = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_IR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_hold_ip_flag,
    input  logic                  i_reset_ip,
    input  logic                  i_select_jump_address,
    input  logic                  i_condition,
    input  logic                  i_ir_enable,
    input  logic                  i_memory_address_source,
    input  logic                  i_memory_read_enable,
    input  logic                  i_memory_write_enable,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_rd,
    output logic                  o_mem_wr,
    output logic [DATA_WIDTH-1:0] o_ir,
    output logic [ADDR_WIDTH-1:0] o_ip,
    output logic [ADDR_WIDTH-1:0] o_opnd_addr,
    output logic                  o_run,
    output logic [15:0]           o_retired
);

    localparam int unsigned RET_W = 16;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ip_q, ip_d;
    logic [ADDR_WIDTH-1:0]   opnd_q, opnd_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic                    rd_q, rd_d;
    logic                    ir_q, ir_d;
    logic                    src_q, src_d;

    logic                    mem_rd_c;
    logic                    mem_wr_c;
    logic [ADDR_WIDTH-1:0]   mem_addr_c;
    logic                    ir_load_c;
    logic                    ip_restart_c;

    // Memory strobes and address: only S_RUN follows the decoder, priming always reads at IP.
    always_comb begin
        mem_rd_c   = 1'b0;
        mem_wr_c   = 1'b0;
        mem_addr_c = ip_q;
        case (state_q)
            S_PRIME: mem_rd_c = 1'b1;
            S_RUN: begin
                mem_wr_c = i_memory_write_enable;
                mem_rd_c = i_memory_read_enable & ~i_memory_write_enable;
                if (i_memory_address_source) begin
                    mem_addr_c = opnd_q;
                end
            end
            default: ;
        endcase
    end

    // Next-state: sequencing, read-return capture and IP priority chain.
    always_comb begin
        state_d      = state_q;
        ip_d         = ip_q;
        opnd_d       = opnd_q;
        instr_d      = instr_q;
        rd_d         = mem_rd_c;
        ir_d         = i_ir_enable;
        src_d        = i_memory_address_source;
        ir_load_c    = 1'b0;
        ip_restart_c = 1'b0;
        case (state_q)
            S_RESET: begin
                state_d = S_PRIME;
                ir_d    = 1'b0;
                src_d   = 1'b0;
            end
            S_PRIME: begin
                state_d = S_RUN;
                ir_d    = 1'b1;
                src_d   = 1'b0;
                ip_d    = ip_q + ADDR_WIDTH'(1);
            end
            S_RUN: begin
                if (i_reset_ip) begin
                    // Restart: the returning word and the read issued now are both dropped.
                    state_d      = S_RESET;
                    ip_d         = RESET_IP;
                    instr_d      = RESET_IR;
                    rd_d         = 1'b0;
                    ir_d         = 1'b0;
                    src_d        = 1'b0;
                    ip_restart_c = 1'b1;
                end else begin
                    if (rd_q && ir_q) begin
                        instr_d   = i_mem_rdata;
                        ir_load_c = 1'b1;
                    end else if (rd_q && !src_q) begin
                        opnd_d = ADDR_WIDTH'(i_mem_rdata);
                    end

                    if (i_hold_ip_flag || i_memory_write_enable) begin
                        ip_d = ip_q;
                    end else if (i_select_jump_address && i_condition) begin
                        ip_d = opnd_q;
                    end else if (i_memory_read_enable && i_memory_address_source) begin
                        ip_d = opnd_q + ADDR_WIDTH'(1);
                    end else if (i_memory_read_enable) begin
                        ip_d = ip_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            ip_q    <= RESET_IP;
            opnd_q  <= '0;
            instr_q <= RESET_IR;
            rd_q    <= 1'b0;
            ir_q    <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            opnd_q  <= opnd_d;
            instr_q <= instr_d;
            rd_q    <= rd_d;
            ir_q    <= ir_d;
            src_q   <= src_d;
        end
    end

`ifdef IP_TRACE_EN
    logic [RET_W-1:0] retired_q, retired_d;

    // Saturating count of IR loads, cleared on IP restart.
    always_comb begin
        retired_d = retired_q;
        if (ip_restart_c) begin
            retired_d = '0;
        end else if (ir_load_c && (retired_q != '1)) begin
            retired_d = retired_q + RET_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign o_retired = retired_q;
`else
    logic unused_trace_c;
    assign unused_trace_c = ir_load_c ^ ip_restart_c;
    assign o_retired      = RET_W'(0);
`endif

    assign o_mem_addr  = mem_addr_c;
    assign o_mem_rd    = mem_rd_c;
    assign o_mem_wr    = mem_wr_c;
    assign o_ir        = instr_q;
    assign o_ip        = ip_q;
    assign o_opnd_addr = opnd_q;
    assign o_run       = (state_q == S_RUN);

endmodule

// File: tb/tb_ip_fetch_unit.sv
// Bench for ip_fetch_unit: directed test-plan sequences then randomized decoder traffic,
// all checked each cycle against a transaction-level model of IP, operand latch and IR.
module tb_ip_fetch_unit;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam logic [AW-1:0] R_IP = 8'h00;
    localparam logic [DW-1:0] R_IR = 8'h00;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold_ip, reset_ip, sel_jump, cond, ir_en, src, rd_en, wr_en;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] ir;
    logic [AW-1:0] ip, opnd;
    logic          run;
    logic [15:0]   retired;

    logic [DW-1:0] mem [256];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: phase 0 = restarting, 1 = priming, 2 = running.
    int            phase = 0;
    bit            known = 0;
    logic [AW-1:0] m_ip, m_opnd;
    logic [DW-1:0] m_ir;
    int            m_ret;
    bit            p_valid, p_to_ir, p_operand;
    logic [DW-1:0] p_data;

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[mem_addr];

    ip_fetch_unit #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RESET_IP  (R_IP),
        .RESET_IR  (R_IR)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .i_hold_ip_flag         (hold_ip),
        .i_reset_ip             (reset_ip),
        .i_select_jump_address  (sel_jump),
        .i_condition            (cond),
        .i_ir_enable            (ir_en),
        .i_memory_address_source(src),
        .i_memory_read_enable   (rd_en),
        .i_memory_write_enable  (wr_en),
        .i_mem_rdata            (rdata),
        .o_mem_addr             (mem_addr),
        .o_mem_rd               (mem_rd),
        .o_mem_wr               (mem_wr),
        .o_ir                   (ir),
        .o_ip                   (ip),
        .o_opnd_addr            (opnd),
        .o_run                  (run),
        .o_retired              (retired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model.
    task automatic step(input bit rst, input bit hold, input bit rip, input bit jmp,
                        input bit c, input bit ire, input bit s, input bit rd, input bit wr);
        logic [AW-1:0] e_addr;
        logic [AW-1:0] old_opnd;
        bit            e_rd, e_wr;
        int            e_ret;
        @(negedge clk);
        rst_n = rst; hold_ip = hold; reset_ip = rip; sel_jump = jmp; cond = c;
        ir_en = ire; src = s; rd_en = rd; wr_en = wr;
        #1;
        if (phase == 2) begin
            e_rd = rd && !wr;
            e_wr = wr;
            e_addr = s ? m_opnd : m_ip;
        end else begin
            e_rd = (phase == 1);
            e_wr = 1'b0;
            e_addr = m_ip;
        end
`ifdef IP_TRACE_EN
        e_ret = m_ret;
`else
        e_ret = 0;
`endif
        if (known) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_rd",   32'(mem_rd),   32'(e_rd));
            chk("mem_wr",   32'(mem_wr),   32'(e_wr));
            chk("ip",       32'(ip),       32'(m_ip));
            chk("ir",       32'(ir),       32'(m_ir));
            chk("opnd",     32'(opnd),     32'(m_opnd));
            chk("run",      32'(run),      32'(phase == 2));
            chk("retired",  32'(retired),  32'(e_ret));
        end
        if (!rst) begin
            phase = 0; m_ip = R_IP; m_ir = R_IR; m_opnd = '0; p_valid = 0; m_ret = 0; known = 1;
        end else if (phase == 0) begin
            phase = 1; p_valid = 0;
        end else if (phase == 1) begin
            phase = 2; p_valid = 1; p_data = mem[m_ip]; p_to_ir = 1; p_operand = 0;
            m_ip = m_ip + 8'd1;
        end else if (rip) begin
            phase = 0; m_ip = R_IP; m_ir = R_IR; p_valid = 0; m_ret = 0;
        end else begin
            old_opnd = m_opnd;
            if (p_valid && p_to_ir) begin
                m_ir = p_data;
                if (m_ret < 65535) m_ret++;
            end else if (p_valid && p_operand) begin
                m_opnd = p_data;
            end
            if (hold || wr)       m_ip = m_ip;
            else if (jmp && c)    m_ip = old_opnd;
            else if (rd && s)     m_ip = old_opnd + 8'd1;
            else if (rd)          m_ip = m_ip + 8'd1;
            p_valid = e_rd; p_data = mem[e_addr]; p_to_ir = ire; p_operand = !s;
        end
    endtask

    task automatic idle();           step(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic fetch();          step(1, 0, 0, 0, 0, 1, 0, 1, 0); endtask
    task automatic load_opnd();      step(1, 0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic jump(input bit c); step(1, 0, 0, 1, c, 0, 0, 0, 0); endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'h11; mem[8'h01] = 8'hFE; mem[8'h02] = 8'h05;
        mem[8'h05] = 8'h40; mem[8'h40] = 8'h5A; mem[8'h41] = 8'h20;
        mem[8'h21] = 8'h09;

        // Reset and release, priming from address 0.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("lit_reset_rd", 32'(mem_rd), 32'd0);
        chk("lit_reset_run", 32'(run), 32'd0);
        idle();
        chk("lit_prime_rd", 32'(mem_rd), 32'd1);
        chk("lit_prime_addr", 32'(mem_addr), 32'h00);
        idle();
        chk("lit_run", 32'(run), 32'd1);
        chk("lit_ip1", 32'(ip), 32'h01);
        idle();
        chk("lit_ir11", 32'(ir), 32'h11);

        // Operand FE, jump there, sequential fetch across the wrap.
        load_opnd(); idle();
        jump(1);
        chk("lit_opnd_fe", 32'(opnd), 32'hFE);
        fetch(); chk("lit_addr_fe", 32'(mem_addr), 32'hFE);
        fetch(); chk("lit_addr_ff", 32'(mem_addr), 32'hFF);
        fetch(); chk("lit_addr_00", 32'(mem_addr), 32'h00);
        fetch(); chk("lit_addr_01", 32'(mem_addr), 32'h01);
        idle();  chk("lit_ip_wrap", 32'(ip), 32'h02);

        // Operand then transfer through the operand latch.
        load_opnd(); idle(); jump(1);
        load_opnd(); chk("lit_ip5", 32'(ip), 32'h05);
        idle();
        step(1, 0, 0, 0, 0, 1, 1, 1, 0);
        chk("lit_xfer_addr", 32'(mem_addr), 32'h40);
        idle(); chk("lit_xfer_ip", 32'(ip), 32'h41);
        idle(); chk("lit_xfer_ir", 32'(ir), 32'h5A);

        // Conditional jump taken and not taken.
        load_opnd(); idle(); jump(1);
        idle(); chk("lit_jump_taken", 32'(ip), 32'h20);
        step(1, 0, 0, 1, 0, 1, 0, 1, 0);
        idle(); chk("lit_jump_fall", 32'(ip), 32'h21);

        // Hold with reads, then read+write collision.
        load_opnd(); idle(); jump(1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 1, 0, 1, 0);
            chk("lit_hold_rd", 32'(mem_rd), 32'd1);
            chk("lit_hold_ip", 32'(ip), 32'h09);
        end
        step(1, 0, 0, 0, 0, 1, 0, 1, 1);
        chk("lit_rw_rd", 32'(mem_rd), 32'd0);
        chk("lit_rw_wr", 32'(mem_wr), 32'd1);
        chk("lit_rw_ip", 32'(ip), 32'h09);

        // reset_ip with a read in flight.
        fetch();
        step(1, 0, 1, 0, 0, 1, 0, 1, 0);
        idle();
        chk("lit_rip_ip", 32'(ip), 32'(R_IP));
        chk("lit_rip_ir", 32'(ir), 32'(R_IR));
        chk("lit_rip_run", 32'(run), 32'd0);
        chk("lit_rip_ret", 32'(retired), 32'd0);
        idle(); idle(); idle(); fetch(); fetch();

        // rst_n low while a read is returning.
        step(0, 0, 0, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_ir", 32'(ir), 32'(R_IR));
        chk("lit_rst_ip", 32'(ip), 32'(R_IP));
        chk("lit_rst_ret", 32'(retired), 32'd0);

        // Randomized decoder traffic.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ip_fetch_unit.md
Name: ip_fetch_unit

Overview:
Instruction-pointer and fetch stage directly upstream of the instruction decoder. It owns the IP register, the operand-address latch and the instruction register (IR). It drives the program-memory address, read and write strobes, and feeds the registered IR word to the decoder. Its IP, address mux and IR capture are controlled by the decoder's outputs from the previous decode: hold, reset-IP, jump select, IR enable and address source.

Parameters:
DATA_WIDTH, 8, memory word and IR width.
ADDR_WIDTH, 8, program-memory address width.
RESET_IP, 0, IP value loaded on reset or reset-IP.
RESET_IR, 0, IR value while not yet primed; must equal the decoder's RESET opcode.

Ports:
clk  in  1  clock.
rst_n  in  1  reset.
i_hold_ip_flag  in  1  freeze IP.
i_reset_ip  in  1  restart from RESET_IP.
i_select_jump_address  in  1  conditional jump request.
i_condition  in  1  ALU condition flag, sampled with the jump request.
i_ir_enable  in  1  capture the fetched word into the IR.
i_memory_address_source  in  1  0 = IP, 1 = operand latch.
i_memory_read_enable  in  1  read request.
i_memory_write_enable  in  1  write request.
i_mem_rdata  in  DATA_WIDTH  synchronous-read memory data, valid 1 cycle after the address.
o_mem_addr  out  ADDR_WIDTH  memory address (combinational mux).
o_mem_rd  out  1  memory read strobe.
o_mem_wr  out  1  memory write strobe.
o_ir  out  DATA_WIDTH  instruction word to the decoder.
o_ip  out  ADDR_WIDTH  current IP.
o_opnd_addr  out  ADDR_WIDTH  operand latch.
o_run  out  1  1 in S_RUN only.
o_retired  out  16  instruction count (optional feature).

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. In reset:
  - ip = RESET_IP, o_ir = RESET_IR, opnd = 0, state = S_RESET.
  - rd_q = 0, ir_q = 0, src_q = 0, o_retired = 0.
  - o_mem_rd = 0, o_mem_wr = 0, o_run = 0.
- States: S_RESET -> S_PRIME -> S_RUN.
  - S_RESET (1 cycle): no strobes; o_mem_addr = ip.
  - S_PRIME (1 cycle): o_mem_rd = 1, addr = ip; sets rd_q = 1, ir_q = 1, src_q = 0; ip <= ip + 1.
  - S_RUN: strobes follow the decoder inputs.
- In S_RUN, i_reset_ip = 1: ip <= RESET_IP, o_ir <= RESET_IR, state <= S_RESET. The pending read is discarded (rd_q <= 0).
- Address mux: o_mem_addr = i_memory_address_source ? opnd : ip.
- Strobes: o_mem_wr = i_memory_write_enable. o_mem_rd = i_memory_read_enable & ~i_memory_write_enable, so write wins if both are asserted.
- Read tracking: rd_q <= o_mem_rd, ir_q <= i_ir_enable, src_q <= i_memory_address_source, registered each cycle.
- Return data (1 cycle later, when rd_q = 1):
  - ir_q = 1: o_ir <= i_mem_rdata.
  - src_q = 0 and ir_q = 0: opnd <= i_mem_rdata (operand word).
  - Otherwise o_ir holds. The decoder re-decodes the same word, which gives repeat/hold semantics.
- IP update in S_RUN, highest priority first:
  1. reset_ip.
  2. hold -> ip unchanged.
  3. write -> unchanged.
  4. jump with i_condition = 1 -> ip <= opnd.
  5. read with source = 1 -> ip <= opnd + 1 (transfer; the word at opnd is being fetched).
  6. read with source = 0 -> ip <= ip + 1.
  7. Otherwise unchanged.
- Jump with i_condition = 0 falls through to rule 6.
- Arithmetic: all IP arithmetic is modulo 2^ADDR_WIDTH; wrap from all-ones to 0 is silent.
- Reset mid-operation: rst_n low in any state forces the reset values on the next edge; in-flight read data is ignored.

Optional Feature:
- Macro: IP_TRACE_EN.
- Defined: o_retired increments on each IR load in S_RUN and saturates at 16'hFFFF. It clears on reset and on reset_ip.
- Undefined: o_retired is tied to 0 and no counter logic is present.

Test Plan:
- Reset then release, memory[0] = 8'h11 -> S_RESET 1 cycle, S_PRIME reads addr 0, o_ir = 8'h11 two cycles after release, o_ip = 1, o_run = 1.
- Sequential fetch with ir_enable = 1 and source = 0 for 4 cycles from ip = 8'hFE -> addresses FE, FF, 00, 01 (wrap), each word in o_ir one cycle after its address.
- Operand then transfer: read with ir_enable = 0 at ip = 5 returns 8'h40; next cycle source = 1 -> o_mem_addr = 8'h40, o_ip = 8'h41, o_ir = memory[0x40].
- Jump: opnd = 8'h20, select_jump = 1 with i_condition = 1 -> ip = 8'h20; same with i_condition = 0 -> ip = old ip + 1.
- hold = 1 with read = 1 for 3 cycles at ip = 9 -> ip stays 9, o_mem_rd = 1 each cycle; read + write together -> o_mem_rd = 0, o_mem_wr = 1.
- reset_ip asserted mid-run, and separately rst_n low while rd_q = 1 -> ip = RESET_IP, o_ir = RESET_IR, stale data not captured; with IP_TRACE_EN, o_retired = 0.
